// File: rtl/puf_eval_ctrl.sv
// Arbiter PUF evaluation sequencer: launches NUM_EVALS races per challenge and majority-votes the response.
// Build option: define PUF_STABILITY_EN to compute the per-bit stable_mask; otherwise it reads all ones.
module puf_eval_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_EVALS     = 8
) (
  input  logic        s00_axi_aclk,
  input  logic        s00_axi_aresetn,
  input  logic        start,
  input  logic [63:0] challenge,
  output logic        busy,
  output logic        done,
  output logic [63:0] response,
  output logic [63:0] stable_mask,
  output logic        puf_a,
  output logic        puf_b,
  output logic [63:0] puf_c,
  input  logic [63:0] puf_resp
);

`ifdef PUF_STABILITY_EN
  localparam bit LP_STAB_EN = 1'b1;
`else
  localparam bit LP_STAB_EN = 1'b0;
`endif

  localparam logic [8:0] LP_SETTLE_M1 = 9'(SETTLE_CYCLES - 1);
  localparam logic [8:0] LP_ARM_M1    = 9'(SETTLE_CYCLES + 1);
  localparam logic [3:0] LP_N         = 4'(NUM_EVALS);
  localparam logic [4:0] LP_N5        = 5'(NUM_EVALS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_ARM, ST_SAMPLE, ST_RELAX, ST_DONE
  } state_t;

  state_t      r_state;
  logic [8:0]  r_timer;
  logic [3:0]  r_evals;
  logic [3:0]  r_cnt [64];
  logic [63:0] r_sync1;
  logic [63:0] r_sync2;
  logic        r_launch;
  logic        r_busy;
  logic        r_done;
  logic [63:0] r_resp;
  logic [63:0] r_stable;
  logic [63:0] r_chal;

  logic [3:0]  w_cnt_nxt [64];
  logic [3:0]  w_evals_nxt;
  logic [63:0] w_vote;
  logic [63:0] w_stable;

  // The array output is asynchronous to the clock, so every bit is double-flopped.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= puf_resp;
      r_sync2 <= r_sync1;
    end
  end

  // Vote and stability use the counts including the sample taken this cycle.
  always_comb begin
    w_vote      = '0;
    w_stable    = '0;
    w_evals_nxt = r_evals + 4'd1;
    for (int i = 0; i < 64; i++) begin
      w_cnt_nxt[i] = r_cnt[i] + {3'b000, r_sync2[i]};
      w_vote[i]    = ({w_cnt_nxt[i], 1'b0} > LP_N5);
      w_stable[i]  = LP_STAB_EN ? ((w_cnt_nxt[i] == 4'd0) || (w_cnt_nxt[i] == LP_N)) : 1'b1;
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      r_state  <= ST_IDLE;
      r_timer  <= '0;
      r_evals  <= '0;
      r_launch <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resp   <= '0;
      r_stable <= '0;
      r_chal   <= '0;
      for (int i = 0; i < 64; i++) r_cnt[i] <= '0;
    end else begin
      r_done <= 1'b0;
      if (!LP_STAB_EN) r_stable <= '1;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_chal  <= challenge;
            r_evals <= '0;
            r_timer <= LP_SETTLE_M1;
            r_busy  <= 1'b1;
            r_state <= ST_LOAD;
            for (int i = 0; i < 64; i++) r_cnt[i] <= '0;
          end
        end
        ST_LOAD, ST_RELAX: begin
          if (r_timer == 9'd0) begin
            r_timer  <= LP_ARM_M1;
            r_launch <= 1'b1;
            r_state  <= ST_ARM;
          end else begin
            r_timer <= r_timer - 9'd1;
          end
        end
        ST_ARM: begin
          if (r_timer == 9'd0) begin
            r_launch <= 1'b0;
            r_state  <= ST_SAMPLE;
          end else begin
            r_timer <= r_timer - 9'd1;
          end
        end
        ST_SAMPLE: begin
          for (int i = 0; i < 64; i++) r_cnt[i] <= w_cnt_nxt[i];
          r_evals <= w_evals_nxt;
          if (w_evals_nxt == LP_N) begin
            r_resp   <= w_vote;
            r_stable <= w_stable;
            r_done   <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            r_timer <= LP_SETTLE_M1;
            r_state <= ST_RELAX;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign response    = r_resp;
  assign stable_mask = r_stable;
  assign puf_a       = r_launch;
  assign puf_b       = r_launch;
  assign puf_c       = r_chal;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Scoreboard bench for puf_eval_ctrl: two instances (N=3 and N=2) driven by behavioural PUF models.
module tb_puf_eval_ctrl;
  localparam int S     = 4;
  localparam int NA    = 3;
  localparam int NB    = 2;
  localparam int LAT_A = S + NA * (S + 3) + (NA - 1) * S;  // 33 edges after the accepting edge
  localparam int LAT_B = S + NB * (S + 3) + (NB - 1) * S;  // 22
`ifdef PUF_STABILITY_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif
  localparam logic [63:0] ONES       = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MASK_NOISY = STAB ? 64'hFFFF_FFFF_FFFF_FFDF : ONES;
  localparam logic [63:0] MASK_TIE   = STAB ? 64'hFFFF_FFFF_FFFF_FFFE : ONES;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic        start_a, busy_a, done_a, pa_a, pb_a;
  logic [63:0] chal_a, resp_a, mask_a, pc_a, presp_a;
  logic        start_b, busy_b, done_b, pa_b, pb_b;
  logic [63:0] chal_b, resp_b, mask_b, pc_b, presp_b;

  puf_eval_ctrl #(.SETTLE_CYCLES(S), .NUM_EVALS(NA)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start_a), .challenge(chal_a),
    .busy(busy_a), .done(done_a), .response(resp_a), .stable_mask(mask_a),
    .puf_a(pa_a), .puf_b(pb_a), .puf_c(pc_a), .puf_resp(presp_a));

  puf_eval_ctrl #(.SETTLE_CYCLES(S), .NUM_EVALS(NB)) dut_b (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n), .start(start_b), .challenge(chal_b),
    .busy(busy_b), .done(done_b), .response(resp_b), .stable_mask(mask_b),
    .puf_a(pa_b), .puf_b(pb_b), .puf_c(pc_b), .puf_resp(presp_b));

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  logic [127:0] exp_b_q[$];
  int t_acc_a = 0, rise_a = 0, base_a = 0, run_a = 0, n_done_a = 0;
  int t_acc_b = 0, rise_b = 0, base_b = 0, n_done_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  bit noisy = 1'b0;

  // PUF models: respond ~challenge while launched; optional single-eval bit flips
  always_comb begin
    presp_a = 64'h0;
    if (pa_a) presp_a = ~pc_a ^ ((noisy && (rise_a - base_a == 2)) ? 64'h20 : 64'h0);
    presp_b = 64'h0;
    if (pa_b) presp_b = ~pc_b ^ ((rise_b - base_b == 1) ? 64'h1 : 64'h0);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor / scoreboard for instance A
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst_n) begin
      run_a  = 0;
      prev_a = 1'b0;
    end else begin
      chk("launch_eq", 64'(pa_a), 64'(pb_a));
      if (pa_a && !prev_a) rise_a++;
      prev_a = pa_a;
      if (pa_a) run_a++;
      else begin
        if (run_a > 0) chk("arm_len", 64'(run_a), 64'(S + 2));
        run_a = 0;
      end
      if (done_a) begin
        n_done_a++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%h expected=none", resp_a);
        end else begin
          e = exp_q.pop_front();
          chk("response", resp_a, e[127:64]);
          chk("stable_mask", mask_a, e[63:0]);
          chk("latency", 64'(cyc - t_acc_a), 64'(LAT_A));
          chk("launches", 64'(rise_a - base_a), 64'(NA));
        end
      end
    end
  end

  // monitor / scoreboard for instance B
  always @(negedge clk) begin
    logic [127:0] e;
    if (!rst_n) prev_b = 1'b0;
    else begin
      if (pa_b && !prev_b) rise_b++;
      prev_b = pa_b;
      if (done_b) begin
        n_done_b++;
        if (exp_b_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done_b actual=%h expected=none", resp_b);
        end else begin
          e = exp_b_q.pop_front();
          chk("tie_response", resp_b, e[127:64]);
          chk("tie_stable_mask", mask_b, e[63:0]);
          chk("tie_latency", 64'(cyc - t_acc_b), 64'(LAT_B));
          chk("tie_launches", 64'(rise_b - base_b), 64'(NB));
        end
      end
    end
  end

  // driver tasks
  task automatic issue_a(input logic [63:0] c, input bit nz, input bit push,
                         input logic [63:0] er, input logic [63:0] em);
    @(negedge clk);
    noisy   = nz;
    start_a = 1'b1;
    chal_a  = c;
    if (push) exp_q.push_back({er, em});
    @(posedge clk);
    #1;
    t_acc_a = cyc;
    base_a  = rise_a;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    int base = n_done_a;
    bit seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=none expected=done");
    end
    repeat (6) @(negedge clk);
    chk("done_pulses", 64'(n_done_a - base), 64'd1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    chk({tag, "_done"}, 64'(done_a), 64'd0);
    chk({tag, "_response"}, resp_a, 64'd0);
    chk({tag, "_stable_mask"}, mask_a, 64'd0);
    chk({tag, "_puf_a"}, 64'(pa_a), 64'd0);
    chk({tag, "_puf_b"}, 64'(pb_a), 64'd0);
    chk({tag, "_puf_c"}, pc_a, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst_n   = 1'b1;
    start_a = 1'b0;
    chal_a  = '0;
    start_b = 1'b0;
    chal_b  = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // stable model
    issue_a(64'hFFFF_0000_FFFF_0000, 1'b0, 1'b1, 64'h0000_FFFF_0000_FFFF, ONES);
    wait_done_a();
    chk("idle_puf_c", pc_a, 64'hFFFF_0000_FFFF_0000);
    chk("idle_busy", 64'(busy_a), 64'd0);

    // bit 5 flips on the second evaluation only
    issue_a(64'h0, 1'b1, 1'b1, ONES, MASK_NOISY);
    wait_done_a();

    // start while busy is ignored
    issue_a(64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 1'b1, 64'h5A5A_A5A5_F0F0_0F0F, ONES);
    repeat (10) @(negedge clk);
    start_a = 1'b1;
    chal_a  = 64'h1;
    @(negedge clk);
    start_a = 1'b0;
    chk("busy_puf_c", pc_a, 64'hA5A5_5A5A_0F0F_F0F0);
    chk("busy_high", 64'(busy_a), 64'd1);
    wait_done_a();
    chk("after_ignore_puf_c", pc_a, 64'hA5A5_5A5A_0F0F_F0F0);

    // start in the DONE cycle ignored, accepted in the next IDLE cycle
    issue_a(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 64'hEDCB_A987_6543_210F, ONES);
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_a) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout2 actual=none expected=done");
    end
    start_a = 1'b1;
    chal_a  = 64'hFFFF_FFFF_0000_0000;
    exp_q.push_back({64'h0000_0000_FFFF_FFFF, ONES});
    @(posedge clk);
    #1;
    chk("done_cycle_start_busy", 64'(busy_a), 64'd0);
    chk("done_cycle_start_puf_c", pc_a, 64'h1234_5678_9ABC_DEF0);
    @(posedge clk);
    #1;
    t_acc_a = cyc;
    base_a  = rise_a;
    start_a = 1'b0;
    chk("idle_start_busy", 64'(busy_a), 64'd1);
    chk("idle_start_puf_c", pc_a, 64'hFFFF_FFFF_0000_0000);
    wait_done_a();

    // reset in the middle of a request
    issue_a(64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 64'h0, 64'h0);
    repeat (15) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    issue_a(64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 64'hFEDC_BA98_7654_3210, ONES);
    wait_done_a();

    // even-tie instance: bit 0 samples 1 then 0
    @(negedge clk);
    start_b = 1'b1;
    chal_b  = 64'hF0F0_F0F0_F0F0_F0F1;
    exp_b_q.push_back({64'h0F0F_0F0F_0F0F_0F0E, MASK_TIE});
    @(posedge clk);
    #1;
    t_acc_b = cyc;
    base_b  = rise_b;
    start_b = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (done_b) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_b_timeout actual=none expected=done");
    end
    repeat (6) @(negedge clk);
    chk("tie_done_pulses", 64'(n_done_b), 64'd1);

    chk("queue_a_drained", 64'(exp_q.size()), 64'd0);
    chk("queue_b_drained", 64'(exp_b_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/puf_eval_ctrl.md
# puf_eval_ctrl

Sequencing controller for the 64-bit arbiter PUF array. On a start request it latches a 64-bit challenge, drives it onto the array, launches NUM_EVALS races on the two delay-line inputs with settle gaps between them, and samples the asynchronous 64-bit response through a two-flop synchroniser. It majority-votes each bit across evaluations and returns a voted response plus a per-bit stability mask. Sits between the AXI register slave of the PUF IP and the PUF array.

## Interface
Parameters:
- SETTLE_CYCLES, 16: cycles the challenge/launch lines are held static before a race or sample; legal 1..255.
- NUM_EVALS, 8: races per request; legal 1..15.

Ports:
- s00_axi_aclk  in  1  sole clock; all logic on its rising edge.
- s00_axi_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE.
- challenge  in  64  challenge; latched in the accepting cycle.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle pulse; response/stable_mask valid from this cycle.
- response  out  64  majority-voted response; held until next done.
- stable_mask  out  64  bit i = 1 if all NUM_EVALS samples of bit i agreed.
- puf_a, puf_b  out  1  race launch lines to the array; always driven equal.
- puf_c  out  64  challenge to the array.
- puf_resp  in  64  raw, asynchronous array output.

## Operation
- States: IDLE, LOAD, ARM, SAMPLE, RELAX, DONE.
- IDLE: busy=0, puf_a=puf_b=0. start=1 -> latch challenge to puf_c, clear per-bit counters and eval counter -> LOAD.
- LOAD: S=SETTLE_CYCLES cycles, launch lines low -> ARM.
- ARM: puf_a=puf_b=1 (both from one register bit) for S+2 cycles -> SAMPLE.
- SAMPLE: 1 cycle; for each bit add synchronised puf_resp[i] to its 4-bit counter; increment eval counter. If evals == NUM_EVALS -> DONE, else -> RELAX.
- RELAX: launch lines low for S cycles -> ARM.
- DONE: 1 cycle; done=1; register response[i] = (2*cnt[i] > NUM_EVALS) (ties for even NUM_EVALS resolve to 0); stable_mask[i] = (cnt[i]==0 || cnt[i]==NUM_EVALS) -> IDLE.
- puf_c constant from LOAD through DONE; retains last challenge in IDLE.
- puf_resp passes through a 2-flop synchroniser on every bit, free-running.
- start while busy ignored, not queued. start high in the DONE cycle ignored; high in the following IDLE cycle accepted.
- Counter arithmetic 4-bit unsigned; cannot overflow given NUM_EVALS<=15.

## Timing
- Reset values: busy=0, done=0, response=0, stable_mask=0, puf_a=puf_b=0, puf_c=0, state IDLE, counters 0, synchroniser flops 0.
- Reset mid-request: all state returns to reset values asynchronously; no done pulse; first request after release starts clean.
- start sampled at edge 0 -> done high in cycle S + NUM_EVALS*(S+3) + (NUM_EVALS-1)*S + 1 (default 281 cycles); busy falls together with done's assertion cycle ending.
- Rising launch edge reaches puf_a/puf_b directly from a flop; no combinational path from any input to any output.

## Configuration
- PUF_STABILITY_EN defined: stable_mask computed as above.
- Not defined: per-bit stability comparison omitted; stable_mask driven constant all ones (still 0 during reset); response unchanged.

## Test plan
- Reset: assert s00_axi_aresetn=0 mid-run -> all outputs 0 immediately; after release, start with challenge 64'h0123_4567_89AB_CDEF completes normally.
- Stable model (puf_resp = ~puf_c when launched), S=4, N=3, challenge 64'hFFFF_0000_FFFF_0000 -> done in cycle 34, response=64'h0000_FFFF_0000_FFFF, stable_mask=all ones, exactly one done pulse.
- Noisy bit: model flips bit 5 on eval 1 only, N=3 -> bit 5 voted to majority value, stable_mask=64'hFFFF_FFFF_FFFF_FFDF (PUF_STABILITY_EN defined) or all ones (undefined).
- Even tie: N=2, bit 0 sampled 1 then 0 -> response[0]=0, stable_mask[0]=0.
- start pulsed at cycle 10 of a busy run with challenge 64'h1 -> ignored; puf_c unchanged; single done.
- Launch check: puf_a==puf_b every cycle; puf_a high for exactly S+2 cycles per eval, N rising edges per request.
